// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings and defaults for the fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam int          DEF_IM_WORDS = 4096;
    localparam logic [31:0] NOP          = 32'h0;

endpackage

// File: rtl/fetch_unit_npc_gen.sv
// npc_gen: combinational next-PC selection from decode-stage redirect info.
module npc_gen
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_d_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] rs_val_i,
    output logic [31:0] npc_o
);
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    assign pc4    = pc_i + 32'd4;
    // Branch offset is relative to the delay-slot address, i.e. the branch's own pc + 4.
    assign br_tgt = pc_d_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    always_comb begin
        npc_o = npc_sel_i == NPC_BRANCH ? (br_taken_i ? br_tgt : pc4) :
                npc_sel_i == NPC_JUMP   ? {pc_d_i[31:28], imm26_i, 2'b00} :
                npc_sel_i == NPC_JR     ? rs_val_i : pc4;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline register, fetch-fault check and run/hold FSM.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          IM_WORDS = DEF_IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16_d,
    input  logic [25:0] imm26_d,
    input  logic [31:0] rs_val_d,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        exc_d
);
    localparam logic [32:0] PC_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    logic [31:0]  pc_q, npc, instr_q, pcd_q, pc8_q;
    logic         exc_q, fault;
    fetch_state_e state_q, state_d;

    npc_gen u_npc_gen (
        .pc_i      (pc_q),
        .pc_d_i    (pcd_q),
        .npc_sel_i (npc_sel),
        .br_taken_i(br_taken),
        .imm16_i   (imm16_d),
        .imm26_i   (imm26_d),
        .rs_val_i  (rs_val_d),
        .npc_o     (npc)
    );

    assign fault = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || ({1'b0, pc_q} >= PC_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pcd_q   <= 32'h0;
            pc8_q   <= 32'h0;
            exc_q   <= 1'b0;
        end else if (!stall) begin
            pc_q    <= npc;
            instr_q <= (flush || fault) ? NOP : instr_in;
            pcd_q   <= flush ? 32'h0 : pc_q;
            pc8_q   <= flush ? 32'h0 : pc_q + 32'd8;
            exc_q   <= !flush && fault;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= reset ? RUN : state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && stall)
            state_d = HOLD;
        else if (state_q == HOLD && !stall)
            state_d = RUN;
    end

    assign pc_out  = pc_q;
    assign instr_d = instr_q;
    assign pc_d    = pcd_q;
    assign pc8_d   = pc8_q;
    assign exc_d   = exc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [1:0]  npc_sel;
    logic [15:0] imm16_d;
    logic [25:0] imm26_d;
    logic [31:0] rs_val_d, pc_out, instr_in, instr_d, pc_d, pc8_d;
    logic        exc_d;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic        m_exc;
    logic [31:0] s_pc, s_instr, s_pcd, s_pc8;
    logic        s_exc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign instr_in = imem(pc_out);

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .npc_sel(npc_sel), .br_taken(br_taken), .imm16_d(imm16_d),
        .imm26_d(imm26_d), .rs_val_d(rs_val_d), .pc_out(pc_out),
        .instr_in(instr_in), .instr_d(instr_d), .pc_d(pc_d),
        .pc8_d(pc8_d), .exc_d(exc_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: valid fetch window is [0x3000, 0x3000 + 4*4096) on word boundaries.
    task automatic model_step();
        longint unsigned p;
        logic [31:0] nxt;
        logic        flt;
        int          off;
        if (reset) begin
            m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_exc = 0;
        end else if (!stall) begin
            p   = m_pc;
            flt = (p % 4 != 0) || (p < 'h3000) || (p >= 'h3000 + 4 * 4096);
            off = $signed(imm16_d) * 4;
            case (npc_sel)
                2'd1:    nxt = br_taken ? m_pcd + 32'd4 + 32'(off) : m_pc + 32'd4;
                2'd2:    nxt = {m_pcd[31:28], imm26_d, 2'b00};
                2'd3:    nxt = rs_val_d;
                default: nxt = m_pc + 32'd4;
            endcase
            if (flush) begin
                m_instr = 0; m_pcd = 0; m_pc8 = 0; m_exc = 0;
            end else begin
                m_instr = flt ? 32'h0 : imem(m_pc);
                m_pcd   = m_pc;
                m_pc8   = m_pc + 32'd8;
                m_exc   = flt;
            end
            m_pc = nxt;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("instr_d", instr_d, m_instr);
        chk("pc_d", pc_d, m_pcd);
        chk("pc8_d", pc8_d, m_pc8);
        chk("exc_d", {31'b0, exc_d}, {31'b0, m_exc});
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; npc_sel = 0; br_taken = 0;
        imm16_d = 0; imm26_d = 0; rs_val_d = 0;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_exc = 0;
        cyc(); cyc();
        reset = 0;
        chk("rst_pc", pc_out, 32'h3000);
        chk("rst_instr", instr_d, 32'h0);
        cyc();
        chk("run_pc1", pc_out, 32'h3004);
        chk("run_instr1", instr_d, imem(32'h3000));
        cyc();
        chk("run_pc2", pc_out, 32'h3008);
        chk("run_pcd2", pc_d, 32'h3004);
        cyc(); cyc(); cyc();
        chk("pre_br_pcd", pc_d, 32'h3010);
        npc_sel = 1; br_taken = 1; imm16_d = 16'hFFFC;
        cyc();
        chk("br_taken_pc", pc_out, 32'h3004);
        chk("br_slot_pcd", pc_d, 32'h3014);
        br_taken = 0;
        cyc();
        chk("br_not_taken_pc", pc_out, 32'h3008);
        npc_sel = 3; rs_val_d = 32'h3020;
        cyc();
        npc_sel = 0;
        cyc();
        chk("jal_pcd", pc_d, 32'h3020);
        chk("jal_pc8", pc8_d, 32'h3028);
        npc_sel = 2; imm26_d = 26'h0C10;
        cyc();
        chk("jal_pc", pc_out, 32'h0000_3040);
        npc_sel = 0;
        cyc();
        s_pc = pc_out; s_instr = instr_d; s_pcd = pc_d; s_pc8 = pc8_d; s_exc = exc_d;
        stall = 1; flush = 1; npc_sel = 3; rs_val_d = 32'h5555_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc_out, s_pc);
            chk("stall_instr", instr_d, s_instr);
            chk("stall_pcd", pc_d, s_pcd);
            chk("stall_pc8", pc8_d, s_pc8);
            chk("stall_exc", {31'b0, exc_d}, {31'b0, s_exc});
        end
        stall = 0; npc_sel = 0;
        cyc();
        chk("flush_instr", instr_d, 32'h0);
        chk("flush_exc", {31'b0, exc_d}, 32'h0);
        chk("flush_pc_adv", pc_out, s_pc + 32'd4);
        flush = 0;
        npc_sel = 3; rs_val_d = 32'h3002;
        cyc();
        npc_sel = 0;
        cyc();
        chk("misalign_exc", {31'b0, exc_d}, 32'h1);
        chk("misalign_instr", instr_d, 32'h0);
        chk("misalign_pcd", pc_d, 32'h3002);
        npc_sel = 3; rs_val_d = 32'h7000;
        cyc();
        npc_sel = 0;
        cyc();
        chk("oob_hi_exc", {31'b0, exc_d}, 32'h1);
        chk("oob_hi_instr", instr_d, 32'h0);
        npc_sel = 3; rs_val_d = 32'h6FFC;
        cyc();
        npc_sel = 0;
        cyc();
        chk("last_word_exc", {31'b0, exc_d}, 32'h0);
        chk("last_word_instr", instr_d, imem(32'h6FFC));
        npc_sel = 3; rs_val_d = 32'h2FFC;
        cyc();
        npc_sel = 0;
        cyc();
        chk("oob_lo_exc", {31'b0, exc_d}, 32'h1);
        stall = 1; npc_sel = 3; rs_val_d = 32'h4000;
        cyc();
        reset = 1;
        cyc();
        chk("rst_stall_pc", pc_out, 32'h3000);
        chk("rst_stall_instr", instr_d, 32'h0);
        chk("rst_stall_pcd", pc_d, 32'h0);
        chk("rst_stall_pc8", pc8_d, 32'h0);
        reset = 0; stall = 0; npc_sel = 0;
        cyc();
        chk("post_rst_pc", pc_out, 32'h3004);
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 3);
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 15);
            npc_sel  = 2'($urandom_range(0, 3));
            br_taken = 1'($urandom_range(0, 1));
            imm16_d  = 16'($urandom);
            imm26_d  = 26'($urandom);
            rs_val_d = ($urandom_range(0, 9) == 0) ? $urandom :
                       32'h2FF0 + 32'($urandom_range(0, 32'h4020));
            cyc();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
